// File: rtl/seq_gen.sv
// Nibble-sequence stimulus generator: emits one LEN-nibble frame per start, waits for the
// classifier verdict (or a timeout), and keeps saturating pass/fail counts.
module seq_gen #(
  parameter int unsigned LEN     = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [3:0] seed,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       resp_valid,
  input  logic       resp_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt
);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StReport} state_e;

  localparam logic [3:0] IncMax   = 4'(16 - LEN);
  localparam logic [3:0] DecMin   = 4'(LEN - 1);
  localparam logic [2:0] LastIdx  = 3'(LEN - 1);
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] seed_q, seed_d;
  logic [3:0] base_q, base_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       verdict_q, verdict_d;
  logic       to_q, to_d;
  logic       out_valid_d, busy_d, done_d, pass_d, timeout_d;
  logic [3:0] out_data_d;
  logic [7:0] pass_cnt_d, fail_cnt_d;
  logic [3:0] nib;

  always_comb begin
    nib = seed_q;
    unique case (mode_q)
      2'd0:    nib = base_q + {1'b0, idx_q};
      2'd1:    nib = base_q - {1'b0, idx_q};
      2'd2:    nib = idx_q[0] ? (seed_q ^ 4'h8) : seed_q;
      default: nib = seed_q;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    base_d      = base_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    verdict_d   = verdict_q;
    to_d        = to_q;
    pass_cnt_d  = pass_cnt;
    fail_cnt_d  = fail_cnt;
    out_valid_d = 1'b0;
    out_data_d  = 4'h0;
    done_d      = 1'b0;
    pass_d      = 1'b0;
    timeout_d   = 1'b0;
    busy_d      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSend;
          mode_d  = mode;
          seed_d  = seed;
          idx_d   = 3'd0;
          if (mode == 2'd0) base_d = (seed > IncMax) ? IncMax : seed;
          else              base_d = (seed < DecMin) ? DecMin : seed;
        end
      end
      StSend: begin
        out_valid_d = 1'b1;
        out_data_d  = nib;
        if (idx_q == LastIdx) begin
          state_d   = StWait;
          wcnt_d    = 8'd0;
          verdict_d = 1'b0;
          to_d      = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StWait: begin
        // A response on the final wait cycle takes priority over the timeout.
        if (resp_valid) begin
          verdict_d = resp_data;
          state_d   = StReport;
        end else if (wcnt_q == WaitLast) begin
          to_d    = 1'b1;
          state_d = StReport;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      StReport: begin
        done_d    = 1'b1;
        timeout_d = to_q;
        pass_d    = !to_q && (verdict_q == !mode_q[1]);
        if (pass_d) begin
          if (pass_cnt != 8'hFF) pass_cnt_d = pass_cnt + 8'd1;
        end else begin
          if (fail_cnt != 8'hFF) fail_cnt_d = fail_cnt + 8'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mode_q    <= 2'd0;
      seed_q    <= 4'h0;
      base_q    <= 4'h0;
      idx_q     <= 3'd0;
      wcnt_q    <= 8'd0;
      verdict_q <= 1'b0;
      to_q      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      pass_cnt  <= 8'd0;
      fail_cnt  <= 8'd0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      verdict_q <= verdict_d;
      to_q      <= to_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      timeout   <= timeout_d;
      pass_cnt  <= pass_cnt_d;
      fail_cnt  <= fail_cnt_d;
    end
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Stimulus generator and response checker for the nibble-sequence protocol: the transmitting end for a 1-bit sequence classifier. On a start command it emits one frame of `LEN` 4-bit nibbles under a valid strobe. The frame follows a selected pattern. The block then waits for the classifier's 1-bit verdict, compares it with the expected verdict, and keeps saturating pass/fail counts. It sits in the lab test harness between the control sequencer and the classifier under test.

## Interface
Parameters:
- `LEN`, default 3: nibbles per frame, legal range 3..8.
- `TIMEOUT`, default 16: WAIT cycles allowed before the response is declared missing, legal range 1..255.

Ports:
- `clk`  in  1: the single clock; all flops are rising-edge.
- `rst`  in  1: reset is asynchronous and active-high; one clock domain.
- `start`  in  1: frame request; honoured only in IDLE, ignored elsewhere.
- `mode`  in  2: pattern select, latched with `start`.
- `seed`  in  4: base nibble, latched with `start`.
- `out_valid`  out  1: frame strobe to the classifier.
- `out_data`  out  4: frame nibble.
- `resp_valid`  in  1: classifier verdict strobe.
- `resp_data`  in  1: classifier verdict.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `pass`  out  1: verdict matched; meaningful only while `done` is high.
- `timeout`  out  1: no response arrived; meaningful only while `done` is high.
- `pass_cnt`  out  8: saturating count of passed frames.
- `fail_cnt`  out  8: saturating count of failed or timed-out frames.

## Operation
- All outputs are registered. Reset drives every output to 0 and the FSM to IDLE, asynchronously, including in the middle of a frame. After reset release, the next frame starts cleanly.
- FSM states:
  - IDLE: `start`=1 → SEND. `mode` and `seed` are latched and the nibble index is cleared.
  - SEND: emits nibble k = 0..LEN-1, one per cycle. After the last nibble → WAIT.
  - WAIT: `resp_valid`=1 → REPORT with the verdict captured. Timeout count reaching `TIMEOUT` → REPORT with timeout flagged.
  - REPORT: one cycle. Drives `done`, updates the counters, → IDLE.
- Patterns. `s` is the latched seed; nibble k is:
  - mode 0, strictly increasing: b + k, where b = min(s, 16-LEN). Expected verdict 1.
  - mode 1, strictly decreasing: b − k, where b = max(s, LEN-1). Expected verdict 1.
  - mode 2, zig-zag: s for even k, s^4'h8 for odd k. Expected verdict 0.
  - mode 3, constant: s for every k. Expected verdict 0.
- Nibble arithmetic is 4-bit. The clamps above guarantee no wrap in modes 0 and 1.
- `pass` = (captured `resp_data` == expected) and not timeout.
- Counters:
  - On `done`, `pass_cnt` increments if `pass`; otherwise `fail_cnt` increments.
  - Each counter saturates at 255 and clears only on reset.
- `resp_valid` outside WAIT is ignored and has no effect on any counter.
- `start` while `busy` is ignored, not queued.

## Timing
- `start` sampled at edge E:
  - `out_valid`=1 from edge E+1 through edge E+LEN, exactly LEN consecutive cycles with no gaps.
  - `out_data` holds nibble k during cycle k+1 after E.
  - `out_data` = 0 whenever `out_valid`=0.
- WAIT begins at edge E+LEN. The timeout counter starts at 0 there and increments once per WAIT cycle.
- `resp_valid` sampled high at edge R in WAIT → `done`=1 during the cycle after edge R+1. That is one-cycle REPORT latency, and the counters change at that same edge.
- If `resp_valid` arrives in the same cycle that the timeout count reaches `TIMEOUT`, the response wins and `timeout`=0.
- Timeout path: `done` and `timeout` assert TIMEOUT+1 cycles after WAIT entry, with `pass`=0.
- `busy`:
  - rises with the first `out_valid` cycle;
  - falls the cycle after `done`.
  - The next `start` may be sampled in the first IDLE cycle, giving a back-to-back period of LEN+2+response delay.

## Test plan
- Reset then mode 0, seed 4'hE, LEN=3 → nibbles D,E,F. Respond 1 one cycle after the frame → `done`=1, `pass`=1, `pass_cnt`=1.
- Mode 1, seed 1 → nibbles 2,1,0. Respond 0 → `pass`=0, `fail_cnt`=1. Mode 2, seed 3 → nibbles 3,B,3. Respond 0 → `pass`=1.
- Mode 3, seed 7, no response → `done` with `timeout`=1 exactly 17 cycles after WAIT entry, `fail_cnt` increments. Then a response arriving on the timeout cycle on a second frame → `timeout`=0.
- `start` pulsed during SEND and WAIT, `resp_valid` pulsed during SEND → frame unaffected, no extra counts, exactly 3 `out_valid` cycles.
- `rst` asserted mid-SEND (after nibble 1) → `out_valid`, `busy`, and counters are 0 immediately. A new frame after release is correct from nibble 0.
- 260 passing frames → `pass_cnt` holds 255, `fail_cnt` 0.
